dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single data memory port, including the memory-mapped I/O region at 0xF0000000.
- Port 0 is the CPU memory stage and port 1 is a DMA/loader requester.
- Accepts one access at a time, with round-robin arbitration and a configurable fixed memory latency.
- Returns read data with a one-cycle ack pulse and drives a stall to the CPU pipeline while a CPU access is outstanding.

---
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester arbiter and sequencer for the single data memory port
//   (RAM and the memory-mapped I/O region alike; no address decoding here).
//   Port 0 is the CPU memory stage, port 1 the DMA/loader. One access is in
//   flight at a time; ties are broken round-robin; the memory has a fixed
//   latency of WAIT_CYCLES cycles from mem_en to valid mem_rdata.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request, held stable until cpu_ack
//   cpu_gnt, cpu_ack, cpu_rdata    accept pulse, completion pulse, read data
//   cpu_stall                      cpu_req & ~cpu_ack
//   dma_req/we/addr/wdata          DMA request, same handshake as the CPU
//   dma_gnt, dma_ack, dma_rdata    accept pulse, completion pulse, read data
//   mem_en, mem_we                 one-cycle access strobe, write enable
//   mem_addr, mem_wdata            registered address and write data
//   mem_rdata                      read data, valid WAIT_CYCLES after mem_en
//
// Access timeline (accept at t0):
//   t0 IDLE gnt, t1 ACCESS mem_en, t2..t1+WAIT_CYCLES WAIT, then RESP ack
//   at t0+WAIT_CYCLES+2, back in IDLE the cycle after.

module dmem_arbiter #(
  parameter int DBITS       = 32,
  parameter int ABITS       = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [ABITS-1:0] cpu_addr,
  input  logic [DBITS-1:0] cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_ack,
  output logic [DBITS-1:0] cpu_rdata,
  output logic             cpu_stall,

  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [ABITS-1:0] dma_addr,
  input  logic [DBITS-1:0] dma_wdata,
  output logic             dma_gnt,
  output logic             dma_ack,
  output logic [DBITS-1:0] dma_rdata,

  output logic             mem_en,
  output logic             mem_we,
  output logic [ABITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_wdata,
  input  logic [DBITS-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // The WAIT state is entered one cycle after mem_en, so the counter starts
  // one below the latency and data is captured when it reaches zero.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]       state_reg;
  logic             owner_reg;       // 0 = CPU, 1 = DMA
  logic             last_owner_reg;
  logic [3:0]       cnt_reg;
  logic             we_reg;
  logic [ABITS-1:0] addr_reg;
  logic [DBITS-1:0] wdata_reg;
  logic [DBITS-1:0] cpu_rdata_reg;
  logic [DBITS-1:0] dma_rdata_reg;

  logic             winner;
  logic             accept;

  // DMA wins when it is alone, or on a tie when the CPU had the last turn.
  always_comb begin
    winner = dma_req & (~cpu_req | ~last_owner_reg);
    accept = (state_reg == IDLE) & (cpu_req | dma_req) & ~reset;
  end

  assign cpu_gnt   = accept & ~winner;
  assign dma_gnt   = accept & winner;

  assign cpu_ack   = (state_reg == RESP) & ~owner_reg;
  assign dma_ack   = (state_reg == RESP) & owner_reg;
  assign cpu_stall = cpu_req & ~cpu_ack;

  assign cpu_rdata = cpu_rdata_reg;
  assign dma_rdata = dma_rdata_reg;

  assign mem_en    = (state_reg == ACCESS);
  assign mem_we    = (state_reg == ACCESS) & we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;   // CPU wins the first tie after reset
      cnt_reg        <= 4'd0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      cpu_rdata_reg  <= '0;
      dma_rdata_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            owner_reg      <= winner;
            last_owner_reg <= winner;
            we_reg         <= winner ? dma_we    : cpu_we;
            addr_reg       <= winner ? dma_addr  : cpu_addr;
            wdata_reg      <= winner ? dma_wdata : cpu_wdata;
            state_reg      <= ACCESS;
          end
        end
        ACCESS: begin
          cnt_reg   <= CNT_INIT;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            // Only the owner's read-data register changes, so the other
            // port keeps showing its last result. Writes return zero.
            if (owner_reg) begin
              dma_rdata_reg <= we_reg ? '0 : mem_rdata;
            end else begin
              cpu_rdata_reg <= we_reg ? '0 : mem_rdata;
            end
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Two arbiter instances (WAIT_CYCLES = 1 and 4) run side by side under
//   randomized requesters. A transaction-level reference model tracks each
//   access by its accept cycle and predicts grant, strobe, ack and read data
//   from the arbitration rule and the fixed latency. A simple memory model
//   answers each mem_en with data exactly WAIT_CYCLES later and with noise at
//   every other cycle, so a mistimed sample shows up as wrong read data.

module tb_dmem_arbiter;

  localparam int NI   = 2;
  localparam int NCYC = 2500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance, per-port (0 = CPU, 1 = DMA) stimulus and observation.
  logic        rst_s       [NI];
  logic        req_s       [NI][2];
  logic        we_s        [NI][2];
  logic [31:0] addr_s      [NI][2];
  logic [31:0] wdata_s     [NI][2];
  logic        gnt_s       [NI][2];
  logic        ack_s       [NI][2];
  logic [31:0] rdata_s     [NI][2];
  logic        stall_s     [NI];
  logic        mem_en_s    [NI];
  logic        mem_we_s    [NI];
  logic [31:0] mem_addr_s  [NI];
  logic [31:0] mem_wdata_s [NI];
  logic [31:0] mem_rdata_s [NI];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      dmem_arbiter #(
        .DBITS      (32),
        .ABITS      (32),
        .WAIT_CYCLES(gi == 0 ? 1 : 4)
      ) dut (
        .clk      (clk),
        .reset    (rst_s[gi]),
        .cpu_req  (req_s[gi][0]),
        .cpu_we   (we_s[gi][0]),
        .cpu_addr (addr_s[gi][0]),
        .cpu_wdata(wdata_s[gi][0]),
        .cpu_gnt  (gnt_s[gi][0]),
        .cpu_ack  (ack_s[gi][0]),
        .cpu_rdata(rdata_s[gi][0]),
        .cpu_stall(stall_s[gi]),
        .dma_req  (req_s[gi][1]),
        .dma_we   (we_s[gi][1]),
        .dma_addr (addr_s[gi][1]),
        .dma_wdata(wdata_s[gi][1]),
        .dma_gnt  (gnt_s[gi][1]),
        .dma_ack  (ack_s[gi][1]),
        .dma_rdata(rdata_s[gi][1]),
        .mem_en   (mem_en_s[gi]),
        .mem_we   (mem_we_s[gi]),
        .mem_addr (mem_addr_s[gi]),
        .mem_wdata(mem_wdata_s[gi]),
        .mem_rdata(mem_rdata_s[gi])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: one outstanding access per instance.
  bit          busy_m   [NI];
  int          t_acc_m  [NI];
  int          owner_m  [NI];
  bit          last_m   [NI];
  bit          we_m     [NI];
  logic [31:0] addr_m   [NI];
  logic [31:0] wdata_m  [NI];
  logic [31:0] rdata_m  [NI][2];
  logic [31:0] maddr_m  [NI];
  logic [31:0] mwdata_m [NI];
  bit          rst_prev [NI];

  // Memory model and requester bookkeeping.
  int          resp_at  [NI];
  logic [31:0] resp_val [NI];
  bit          active   [NI][2];
  bit          ack_seen [NI][2];
  int          wait_cnt [NI][2];

  function automatic int wc(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic new_req(input int i, input int p);
    int k;
    k = $urandom_range(0, 3);
    req_s[i][p] = 1'b1;
    we_s[i][p]  = 1'($urandom_range(0, 1));
    case (k)
      0:       addr_s[i][p] = 32'h0000_0100;
      1:       addr_s[i][p] = 32'hF000_0004;
      default: addr_s[i][p] = $urandom & 32'hFFFF_FFFC;
    endcase
    wdata_s[i][p]  = (k == 1) ? 32'h0000_03FF : $urandom;
    active[i][p]   = 1'b1;
    wait_cnt[i][p] = 0;
  endtask

  // Applied just after the rising edge: reset, requester behaviour, memory.
  task automatic drive(input int i, input int c);
    bit ph0;
    ph0 = (c < 40);   // both ports request back-to-back continuously
    if (c < 3 || c == 25) rst_s[i] = 1'b1;
    else rst_s[i] = (c >= 40) && ($urandom_range(0, 99) < 2);
    for (int p = 0; p < 2; p++) begin
      if (active[i][p]) begin
        if (ack_seen[i][p]) begin
          if (ph0 || $urandom_range(0, 1) == 1) new_req(i, p);
          else begin
            active[i][p] = 1'b0;
            req_s[i][p]  = 1'b0;
          end
        end
      end else if (ph0 || $urandom_range(0, 99) < 35) begin
        new_req(i, p);
      end
    end
    mem_rdata_s[i] = (c == resp_at[i]) ? resp_val[i] : $urandom;
  endtask

  // Applied on the falling edge: predict, compare, then advance the model.
  task automatic evaluate(input int i, input int c);
    int    w;
    int    win;
    bit    exp_en;
    bit    ack_cyc;
    bit    exp_ack [2];
    string pre;

    w   = wc(i);
    pre = $sformatf("w%0d c%0d", w, c);

    win = -1;
    if (!busy_m[i] && !rst_s[i]) begin
      if (req_s[i][0] && req_s[i][1]) win = last_m[i] ? 0 : 1;
      else if (req_s[i][0])           win = 0;
      else if (req_s[i][1])           win = 1;
    end

    exp_en  = busy_m[i] && (c == t_acc_m[i] + 1);
    ack_cyc = busy_m[i] && (c == t_acc_m[i] + w + 2);
    if (ack_cyc) rdata_m[i][owner_m[i]] = we_m[i] ? 32'h0 : memval(addr_m[i]);
    exp_ack[0] = ack_cyc && (owner_m[i] == 0);
    exp_ack[1] = ack_cyc && (owner_m[i] == 1);

    check({pre, " cpu_gnt"},   32'(gnt_s[i][0]), 32'(win == 0));
    check({pre, " dma_gnt"},   32'(gnt_s[i][1]), 32'(win == 1));
    check({pre, " mem_en"},    32'(mem_en_s[i]), 32'(exp_en));
    if (exp_en)      check({pre, " mem_we"},       32'(mem_we_s[i]), 32'(we_m[i]));
    if (rst_prev[i]) check({pre, " mem_we_reset"}, 32'(mem_we_s[i]), 32'h0);
    check({pre, " mem_addr"},  mem_addr_s[i],  maddr_m[i]);
    check({pre, " mem_wdata"}, mem_wdata_s[i], mwdata_m[i]);
    check({pre, " cpu_ack"},   32'(ack_s[i][0]), 32'(exp_ack[0]));
    check({pre, " dma_ack"},   32'(ack_s[i][1]), 32'(exp_ack[1]));
    check({pre, " cpu_rdata"}, rdata_s[i][0], rdata_m[i][0]);
    check({pre, " dma_rdata"}, rdata_s[i][1], rdata_m[i][1]);
    check({pre, " cpu_stall"}, 32'(stall_s[i]), 32'(req_s[i][0] && !exp_ack[0]));

    if (ack_cyc)
      $display("[w=%0d] cycle %4d: %s %-5s addr=%h wdata=%h rdata=%h (accepted %0d)",
               w, c, (owner_m[i] == 1) ? "dma" : "cpu", we_m[i] ? "write" : "read",
               addr_m[i], wdata_m[i], rdata_m[i][owner_m[i]], t_acc_m[i]);

    // Memory: a strobe is answered exactly w cycles later.
    if (mem_en_s[i] === 1'b1) begin
      resp_at[i]  = c + w;
      resp_val[i] = memval(mem_addr_s[i]);
    end

    // Requester view of completion, with a liveness bound per request.
    for (int p = 0; p < 2; p++) begin
      ack_seen[i][p] = (ack_s[i][p] === 1'b1);
      if (active[i][p] && !ack_seen[i][p]) begin
        if (rst_s[i]) wait_cnt[i][p] = 0;
        else wait_cnt[i][p]++;
        if (wait_cnt[i][p] >= 60) begin
          check({pre, $sformatf(" ack_timeout_p%0d", p)}, 32'(wait_cnt[i][p]), 32'd0);
          wait_cnt[i][p] = 0;
        end
      end
    end

    // Model transition at the coming edge.
    if (rst_s[i]) begin
      busy_m[i]     = 1'b0;
      last_m[i]     = 1'b1;
      maddr_m[i]    = 32'h0;
      mwdata_m[i]   = 32'h0;
      rdata_m[i][0] = 32'h0;
      rdata_m[i][1] = 32'h0;
    end else if (win >= 0) begin
      busy_m[i]   = 1'b1;
      t_acc_m[i]  = c;
      owner_m[i]  = win;
      last_m[i]   = (win == 1);
      we_m[i]     = we_s[i][win];
      addr_m[i]   = addr_s[i][win];
      wdata_m[i]  = wdata_s[i][win];
      maddr_m[i]  = addr_s[i][win];
      mwdata_m[i] = wdata_s[i][win];
    end else if (ack_cyc) begin
      busy_m[i] = 1'b0;
    end
    rst_prev[i] = rst_s[i];
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_s[i]       = 1'b1;
      mem_rdata_s[i] = 32'h0;
      busy_m[i]      = 1'b0;
      t_acc_m[i]     = 0;
      owner_m[i]     = 0;
      last_m[i]      = 1'b1;
      we_m[i]        = 1'b0;
      addr_m[i]      = 32'h0;
      wdata_m[i]     = 32'h0;
      maddr_m[i]     = 32'h0;
      mwdata_m[i]    = 32'h0;
      rst_prev[i]    = 1'b1;
      resp_at[i]     = -100;
      resp_val[i]    = 32'h0;
      for (int p = 0; p < 2; p++) begin
        req_s[i][p]    = 1'b0;
        we_s[i][p]     = 1'b0;
        addr_s[i][p]   = 32'h0;
        wdata_s[i][p]  = 32'h0;
        rdata_m[i][p]  = 32'h0;
        active[i][p]   = 1'b0;
        ack_seen[i][p] = 1'b0;
        wait_cnt[i][p] = 0;
      end
    end

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) drive(i, c);
      @(negedge clk);
      for (int i = 0; i < NI; i++) evaluate(i, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
